// File: rtl/scroll_background_if.sv
// CPU-side VRAM bus shared by the GPU render blocks.
//   data_in       CPU write data
//   data_out      CPU read data (combinational from the selected region)
//   vram_address  CPU byte address
//   write_enable  write strobe, sampled on the GPU clock
//   SELECT_pmb / SELECT_ntbl / SELECT_ctrl  one-hot region selects
// master: the CPU / decoder side; slave: the render block.
interface scroll_background_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [7:0]            data_in;
  logic [7:0]            data_out;
  logic [ADDR_WIDTH-1:0] vram_address;
  logic                  write_enable;
  logic                  SELECT_pmb;
  logic                  SELECT_ntbl;
  logic                  SELECT_ctrl;

  modport master (
    output data_in, vram_address, write_enable, SELECT_pmb, SELECT_ntbl, SELECT_ctrl,
    input  data_out
  );

  modport slave (
    input  data_in, vram_address, write_enable, SELECT_pmb, SELECT_ntbl, SELECT_ctrl,
    output data_out
  );
endinterface

// File: rtl/scroll_background_m.sv
// Scrolling tile background renderer.
// A wrap-around nametable of 2^NTBL_COLS_LOG2 x 2^NTBL_ROWS_LOG2 tiles is
// viewed through a hardware X/Y scroll. Scroll, colour and enable registers
// are written to a pending copy and copied to the active copy on frame_start,
// so CPU writes during the visible frame never tear the picture.
// Rendering is a two-stage registered pipeline, one pixel per clock.
// Ports:
//   gpu_clk, rst (async, active low)
//   current_x/current_y/pixel_valid  screen position being drawn
//   frame_start                      one-cycle vblank pulse, loads active regs
//   r/g/b/out_valid                  registered pixel, 2 cycles after input
//   cpu                              VRAM bus (slave side)
module scroll_background_m #(
  parameter int ADDR_WIDTH     = 16,
  parameter int NTBL_COLS_LOG2 = 6,
  parameter int NTBL_ROWS_LOG2 = 5,
  parameter int PMB_BASE       = 32'h0000_0200,
  parameter int NTBL_BASE      = 32'h0000_0800,
  parameter int CTRL_BASE      = 32'h0000_1000
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic [7:0] current_x,
  input  logic [7:0] current_y,
  input  logic       pixel_valid,
  input  logic       frame_start,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       out_valid,
  scroll_background_if.slave cpu
);

  localparam int WX_W       = NTBL_COLS_LOG2 + 3;
  localparam int WY_W       = NTBL_ROWS_LOG2 + 3;
  localparam int NTBL_AW    = NTBL_COLS_LOG2 + NTBL_ROWS_LOG2;
  localparam int NTBL_DEPTH = 1 << NTBL_AW;
  // Scroll bits above the world width have no effect, so they are not stored.
  localparam logic [15:0] SX_MASK = 16'((32'd1 << WX_W) - 32'd1);
  localparam logic [15:0] SY_MASK = 16'((32'd1 << WY_W) - 32'd1);

  logic [7:0] pmb_mem_r  [0:511];
  logic [7:0] ntbl_mem_r [0:NTBL_DEPTH-1];

  logic [8:0]         pmb_idx_s;
  logic [NTBL_AW-1:0] ntbl_idx_s;
  logic [2:0]         ctrl_idx_s;

  logic [15:0] scroll_x_p_r, scroll_y_p_r;
  logic [5:0]  colour_p_r;
  logic        enable_p_r;
  logic [15:0] scroll_x_n_s, scroll_y_n_s;
  logic [5:0]  colour_n_s;
  logic        enable_n_s;

  logic [WX_W-1:0] scroll_x_a_r;
  logic [WY_W-1:0] scroll_y_a_r;
  logic [5:0]      colour_a_r;
  logic            enable_a_r;

  logic [WX_W-1:0]    wx_s;
  logic [WY_W-1:0]    wy_s;
  logic [NTBL_AW-1:0] ent_addr_s;

  logic [7:0] ent_r;
  logic [2:0] tx_r, ty_r;
  logic       v1_r;

  logic [2:0]  px_s, py_s;
  logic [15:0] line_s;
  logic [3:0]  sh_s;
  logic [1:0]  pix_s;
  logic [2:0]  colour_s;
  logic [1:0]  r_n_s, g_n_s, b_n_s;

  assign pmb_idx_s  = 9'(cpu.vram_address - ADDR_WIDTH'(PMB_BASE));
  assign ntbl_idx_s = NTBL_AW'(cpu.vram_address - ADDR_WIDTH'(NTBL_BASE));
  assign ctrl_idx_s = 3'(cpu.vram_address - ADDR_WIDTH'(CTRL_BASE));

  // Next value of the pending control registers after a CPU write.
  always_comb begin
    scroll_x_n_s = scroll_x_p_r;
    scroll_y_n_s = scroll_y_p_r;
    colour_n_s   = colour_p_r;
    enable_n_s   = enable_p_r;
    if (cpu.write_enable && cpu.SELECT_ctrl) begin
      case (ctrl_idx_s)
        3'd0:    scroll_x_n_s = {scroll_x_p_r[15:8], cpu.data_in} & SX_MASK;
        3'd1:    scroll_x_n_s = {cpu.data_in, scroll_x_p_r[7:0]} & SX_MASK;
        3'd2:    scroll_y_n_s = {scroll_y_p_r[15:8], cpu.data_in} & SY_MASK;
        3'd3:    scroll_y_n_s = {cpu.data_in, scroll_y_p_r[7:0]} & SY_MASK;
        3'd4:    colour_n_s   = cpu.data_in[5:0];
        3'd5:    enable_n_s   = cpu.data_in[0];
        default: enable_n_s   = enable_p_r;
      endcase
    end else begin
      enable_n_s = enable_p_r;
    end
  end

  // Pending/active control registers; a write on the frame_start edge lands in both.
  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      scroll_x_p_r <= 16'h0000;
      scroll_y_p_r <= 16'h0000;
      colour_p_r   <= 6'd0;
      enable_p_r   <= 1'b0;
      scroll_x_a_r <= '0;
      scroll_y_a_r <= '0;
      colour_a_r   <= 6'd0;
      enable_a_r   <= 1'b0;
    end else begin
      scroll_x_p_r <= scroll_x_n_s;
      scroll_y_p_r <= scroll_y_n_s;
      colour_p_r   <= colour_n_s;
      enable_p_r   <= enable_n_s;
      if (frame_start) begin
        scroll_x_a_r <= scroll_x_n_s[WX_W-1:0];
        scroll_y_a_r <= scroll_y_n_s[WY_W-1:0];
        colour_a_r   <= colour_n_s;
        enable_a_r   <= enable_n_s;
      end
    end
  end

  // CPU writes into pattern and nametable memories (contents survive reset).
  always_ff @(posedge gpu_clk) begin
    if (cpu.write_enable && cpu.SELECT_pmb) begin
      pmb_mem_r[pmb_idx_s] <= cpu.data_in;
    end
    if (cpu.write_enable && cpu.SELECT_ntbl) begin
      ntbl_mem_r[ntbl_idx_s] <= cpu.data_in;
    end
  end

  // CPU read-back mux; nothing selected reads as zero.
  always_comb begin
    cpu.data_out = 8'h00;
    if (cpu.SELECT_pmb) begin
      cpu.data_out = pmb_mem_r[pmb_idx_s];
    end else if (cpu.SELECT_ntbl) begin
      cpu.data_out = ntbl_mem_r[ntbl_idx_s];
    end else if (cpu.SELECT_ctrl) begin
      case (ctrl_idx_s)
        3'd0:    cpu.data_out = scroll_x_p_r[7:0];
        3'd1:    cpu.data_out = scroll_x_p_r[15:8];
        3'd2:    cpu.data_out = scroll_y_p_r[7:0];
        3'd3:    cpu.data_out = scroll_y_p_r[15:8];
        3'd4:    cpu.data_out = {2'b00, colour_p_r};
        3'd5:    cpu.data_out = {7'd0, enable_p_r};
        default: cpu.data_out = 8'h00;
      endcase
    end else begin
      cpu.data_out = 8'h00;
    end
  end

  // World coordinates wrap at the nametable size simply by truncation.
  assign wx_s       = WX_W'(current_x) + scroll_x_a_r;
  assign wy_s       = WY_W'(current_y) + scroll_y_a_r;
  assign ent_addr_s = {wy_s[WY_W-1:3], wx_s[WX_W-1:3]};

  // Stage 1: nametable entry fetch plus in-tile position.
  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      ent_r <= 8'h00;
      tx_r  <= 3'd0;
      ty_r  <= 3'd0;
      v1_r  <= 1'b0;
    end else begin
      ent_r <= ntbl_mem_r[ent_addr_s];
      tx_r  <= wx_s[2:0];
      ty_r  <= wy_s[2:0];
      v1_r  <= pixel_valid;
    end
  end

  // Stage 2 combinational: flips, pattern line fetch, pixel pick, colour gate.
  always_comb begin
    px_s     = ent_r[6] ? (3'd7 - tx_r) : tx_r;
    py_s     = ent_r[5] ? (3'd7 - ty_r) : ty_r;
    line_s   = {pmb_mem_r[{ent_r[4:0], py_s, 1'b0}], pmb_mem_r[{ent_r[4:0], py_s, 1'b1}]};
    sh_s     = {3'd7 - px_s, 1'b0};
    pix_s    = line_s[sh_s +: 2];
    colour_s = ent_r[7] ? colour_a_r[5:3] : colour_a_r[2:0];
    if (v1_r && enable_a_r) begin
      r_n_s = pix_s & {2{colour_s[2]}};
      g_n_s = pix_s & {2{colour_s[1]}};
      b_n_s = pix_s & {2{colour_s[0]}};
    end else begin
      r_n_s = 2'd0;
      g_n_s = 2'd0;
      b_n_s = 2'd0;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge gpu_clk or negedge rst) begin
    if (!rst) begin
      r         <= 2'd0;
      g         <= 2'd0;
      b         <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      r         <= r_n_s;
      g         <= g_n_s;
      b         <= b_n_s;
      out_valid <= v1_r;
    end
  end

endmodule

// File: tb/tb_scroll_background_m.sv
module tb_scroll_background_m;
  localparam int AW = 16;

  logic       gpu_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] current_x = 8'd0;
  logic [7:0] current_y = 8'd0;
  logic       pixel_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] r, g, b;
  logic       out_valid;

  scroll_background_if #(.ADDR_WIDTH(AW)) bus ();

  scroll_background_m #(.ADDR_WIDTH(AW)) dut (
    .gpu_clk(gpu_clk), .rst(rst), .current_x(current_x), .current_y(current_y),
    .pixel_valid(pixel_valid), .frame_start(frame_start),
    .r(r), .g(g), .b(b), .out_valid(out_valid), .cpu(bus)
  );

  always #5 gpu_clk = ~gpu_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference world: 64x32 tile nametable over a 512x256 pixel plane.
  logic [7:0] pmb_m  [512];
  logic [7:0] ntbl_m [2048];
  int m_sx_p, m_sy_p, m_col_p, m_en_p;
  int m_sx_a, m_sy_a, m_col_a, m_en_a;
  logic [6:0] stage_q, out_exp, m_new;
  logic [6:0] obs_q[$];

  // Colour of screen pixel (x,y) from scroll, tile entry and pattern bytes.
  function automatic logic [6:0] model_pix(input int x, input int y);
    int wx, wy, tx, ty, e, base, byt, pix, c;
    logic [1:0] p;
    if (m_en_a == 0) return 7'b100_0000;
    wx = (x + m_sx_a) % 512;
    wy = (y + m_sy_a) % 256;
    e  = int'(ntbl_m[(wy / 8) * 64 + wx / 8]);
    tx = wx % 8;
    ty = wy % 8;
    if ((e & 64) != 0) tx = 7 - tx;
    if ((e & 32) != 0) ty = 7 - ty;
    base = (e % 32) * 16 + ty * 2;
    byt  = (tx < 4) ? int'(pmb_m[base]) : int'(pmb_m[base + 1]);
    pix  = (byt >> (6 - 2 * (tx % 4))) % 4;
    c    = ((e & 128) != 0) ? (m_col_a / 8) % 8 : m_col_a % 8;
    p    = 2'(pix);
    return {1'b1, ((c & 4) != 0) ? p : 2'd0, ((c & 2) != 0) ? p : 2'd0, ((c & 1) != 0) ? p : 2'd0};
  endfunction

  task automatic model_write();
    int a, d, k;
    a = int'(bus.vram_address);
    d = int'(bus.data_in);
    if (bus.write_enable) begin
      if (bus.SELECT_pmb) pmb_m[(a - 32'h200) & 511] = 8'(d);
      else if (bus.SELECT_ntbl) ntbl_m[(a - 32'h800) & 2047] = 8'(d);
      else if (bus.SELECT_ctrl) begin
        k = (a - 32'h1000) & 7;
        case (k)
          0: m_sx_p = ((m_sx_p & 32'hFF00) | d) % 512;
          1: m_sx_p = ((d << 8) | (m_sx_p & 255)) % 512;
          2: m_sy_p = ((m_sy_p & 32'hFF00) | d) % 256;
          3: m_sy_p = ((d << 8) | (m_sy_p & 255)) % 256;
          4: m_col_p = d % 64;
          5: m_en_p = d % 2;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge gpu_clk);
    #2;
  endtask

  task automatic set_bus(input int region, input int idx);
    bus.SELECT_pmb  = (region == 0);
    bus.SELECT_ntbl = (region == 1);
    bus.SELECT_ctrl = (region == 2);
    case (region)
      0: bus.vram_address = AW'(32'h200 + idx);
      1: bus.vram_address = AW'(32'h800 + idx);
      2: bus.vram_address = AW'(32'h1000 + idx);
      default: bus.vram_address = AW'(32'h200 + idx);
    endcase
  endtask

  task automatic clr_bus();
    bus.write_enable = 1'b0;
    bus.SELECT_pmb = 1'b0;
    bus.SELECT_ntbl = 1'b0;
    bus.SELECT_ctrl = 1'b0;
  endtask

  // region: 0 pmb, 1 ntbl, 2 ctrl, 3 nothing selected
  task automatic wr(input int region, input int idx, input logic [7:0] d);
    set_bus(region, idx);
    bus.data_in = d;
    bus.write_enable = 1'b1;
    tick();
    clr_bus();
  endtask

  task automatic rd_chk(input string nm, input int region, input int idx, input logic [7:0] want);
    set_bus(region, idx);
    #1;
    chk(nm, int'(bus.data_out), int'(want));
    clr_bus();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic px_run(input int x0, input int y, input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      current_x = 8'(x0 + i);
      current_y = 8'(y);
      pixel_valid = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  // White-colour check of the logged pixels; pixel i is pix[15-2i -: 2].
  task automatic chk_seq(input string nm, input int n, input logic [15:0] pix);
    logic [1:0] p;
    logic [6:0] want, got;
    chk({nm, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n; i++) begin
      p = pix[15 - 2 * i -: 2];
      want = {1'b1, p, p, p};
      got = (i < obs_q.size()) ? obs_q[i] : 7'h00;
      n_cmp++;
      if (i >= obs_q.size() || got !== want) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %0h, want %0h", nm, i, got, want);
      end
    end
  endtask

  initial begin
    bus.data_in = 8'h00;
    bus.vram_address = '0;
    clr_bus();
    fork
      // Reference model plus per-cycle output compare.
      forever begin
        @(posedge gpu_clk);
        if (!rst) begin
          stage_q = 7'd0; out_exp = 7'd0;
          m_sx_p = 0; m_sy_p = 0; m_col_p = 0; m_en_p = 0;
          m_sx_a = 0; m_sy_a = 0; m_col_a = 0; m_en_a = 0;
        end else begin
          m_new = pixel_valid ? model_pix(int'(current_x), int'(current_y)) : 7'd0;
          model_write();
          if (frame_start) begin
            m_sx_a = m_sx_p; m_sy_a = m_sy_p; m_col_a = m_col_p; m_en_a = m_en_p;
          end
          out_exp = stage_q;
          stage_q = m_new;
        end
        #1;
        if (rst) begin
          n_cmp++;
          if ({out_valid, r, g, b} !== out_exp) begin
            n_fail++;
            $display("FAIL pixel @%0t: got v%0d rgb %0d/%0d/%0d, want v%0d rgb %0d/%0d/%0d",
                     $time, out_valid, r, g, b, out_exp[6], out_exp[5:4], out_exp[3:2], out_exp[1:0]);
          end
          if (out_valid) obs_q.push_back({out_valid, r, g, b});
        end
      end
      begin
        tick(); tick();
        chk("reset_out_valid", int'(out_valid), 0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 2048; i++) wr(1, i, 8'h00);
        for (int i = 0; i < 512; i++) wr(0, i, 8'h00);
        wr(0, 16, 8'hE4); wr(0, 17, 8'h1B);          // pattern 1 line 0
        wr(0, 18, 8'h1B); wr(0, 19, 8'hFF);          // pattern 1 line 1
        wr(0, 32, 8'h80); wr(0, 33, 8'h03);          // pattern 2 line 0
        wr(0, 40, 8'h40); wr(0, 41, 8'h00);          // pattern 2 line 4
        wr(0, 48, 8'h40); wr(0, 49, 8'h00);          // pattern 3 line 0
        wr(1, 0, 8'h81); wr(1, 1, 8'h82); wr(1, 2, 8'h83);
        wr(2, 4, 8'h38); wr(2, 5, 8'h01);
        pulse_fs();

        px_run(0, 0, 8); chk_seq("plain_y0", 8, 16'hE41B);
        px_run(0, 1, 8); chk_seq("plain_y1", 8, 16'h1BFF);
        wr(1, 0, 8'hC1);
        px_run(0, 0, 8); chk_seq("hflip_y0", 8, 16'hE41B);
        px_run(0, 1, 8); chk_seq("hflip_y1", 8, 16'hFFE4);
        wr(1, 0, 8'hA1);
        px_run(0, 7, 8); chk_seq("vflip_y7", 8, 16'hE41B);
        px_run(0, 0, 8); chk_seq("vflip_y0", 8, 16'h0000);
        wr(1, 0, 8'h81);

        wr(2, 0, 8'hF4); wr(2, 1, 8'hFF);
        rd_chk("scroll_x_hi_trunc", 2, 1, 8'h01);
        rd_chk("scroll_x_lo", 2, 0, 8'hF4);
        pulse_fs();
        px_run(20, 0, 1); chk_seq("wrap_x20", 1, 16'h8000);
        px_run(27, 0, 1); chk_seq("wrap_x27", 1, 16'hC000);
        wr(2, 2, 8'hFA); wr(2, 3, 8'h00);
        pulse_fs();
        px_run(20, 10, 1); chk_seq("wrap_y10", 1, 16'h4000);

        wr(2, 0, 8'h00); wr(2, 1, 8'h00); wr(2, 2, 8'h00);
        pulse_fs();
        px_run(0, 0, 1); chk_seq("scroll0", 1, 16'hC000);
        wr(2, 0, 8'h10);
        px_run(0, 0, 1); chk_seq("shadow_hold", 1, 16'hC000);
        pulse_fs();
        px_run(0, 0, 1); chk_seq("shadow_load", 1, 16'h4000);
        set_bus(2, 0); bus.data_in = 8'h00; bus.write_enable = 1'b1; frame_start = 1'b1;
        tick();
        clr_bus(); frame_start = 1'b0;
        px_run(0, 0, 1); chk_seq("write_on_fs", 1, 16'hC000);

        wr(2, 5, 8'h00);
        pulse_fs();
        px_run(0, 0, 4); chk_seq("disabled", 4, 16'h0000);
        wr(2, 6, 8'hAA);
        rd_chk("ctrl_idx6", 2, 6, 8'h00);
        rd_chk("colour_rd", 2, 4, 8'h38);
        rd_chk("no_select", 3, 16, 8'h00);
        rd_chk("pmb_rd", 0, 16, 8'hE4);

        wr(2, 5, 8'h01);
        pulse_fs();
        for (int i = 0; i < 3; i++) begin
          current_x = 8'(i); current_y = 8'd0; pixel_valid = 1'b1;
          tick();
        end
        chk("pre_rst_valid", int'(out_valid), 1);
        #3 rst = 1'b0;
        #1;
        chk("rst_async_valid", int'(out_valid), 0);
        chk("rst_async_rgb", int'({r, g, b}), 0);
        pixel_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        rd_chk("rst_scroll_x", 2, 0, 8'h00);
        rd_chk("rst_colour", 2, 4, 8'h00);
        rd_chk("rst_enable", 2, 5, 8'h00);
        rd_chk("keep_pmb", 0, 16, 8'hE4);
        rd_chk("keep_ntbl", 1, 0, 8'h81);
        tick(); tick();
        wr(2, 4, 8'h38); wr(2, 5, 8'h01);
        pulse_fs();
        px_run(0, 0, 8); chk_seq("after_reset", 8, 16'hE41B);
        tick();
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
